// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared constants and types for the program-counter generation
// stage.
//   cause_e  - redirect cause, encoded so that a larger value is a higher
//              priority (EXCP > SRET > EXREDIR > NONE).
//   state_e  - pc_gen FSM states.
//   DEFAULT_RESET_PC / DEFAULT_TRAP_VEC - default parameter values.
//   align_pc - clears bits[1:0] of a fetch target.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_EXREDIR = 2'd1,
    CAUSE_SRET    = 2'd2,
    CAUSE_EXCP    = 2'd3
  } cause_e;

  typedef enum logic {
    PCG_RUN  = 1'b0,
    PCG_PEND = 1'b1
  } state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VEC = 32'h0000_1000;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_gen_redirect_slot.sv
// redirect_slot: one-entry holding slot for a redirect that arrives while the
// ICache is stalled.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   write         - store new_cause/new_target if accept is high
//   clear         - empty the slot (drain)
//   new_cause     - priority of the redirect event seen this cycle
//   new_target    - aligned target of that event
//   accept        - event may overwrite the slot (priority >= stored cause)
//   stored_cause  - cause currently held (CAUSE_NONE when empty)
//   stored_target - target currently held
module redirect_slot
  import pc_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        write,
  input  logic        clear,
  input  cause_e      new_cause,
  input  logic [31:0] new_target,
  output logic        accept,
  output cause_e      stored_cause,
  output logic [31:0] stored_target
);

  // An empty slot holds CAUSE_NONE, so any real event passes the compare.
  // Equal priority overwrites so the newest target of a given kind wins.
  assign accept = (new_cause != CAUSE_NONE) && (new_cause >= stored_cause);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stored_cause  <= CAUSE_NONE;
      stored_target <= '0;
    end else if (clear) begin
      stored_cause  <= CAUSE_NONE;
    end else if (write && accept) begin
      stored_cause  <= new_cause;
      stored_target <= new_target;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program-counter generation stage feeding the fetch stage pc_in.
// Selects the next fetch PC from the fetch-stage prediction, an EX-stage
// redirect, trap entry or sret return; freezes on ICache / hazard stalls and
// parks a redirect that arrives under an ICache stall until the stall clears.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   istall, hazard_stall - ICache miss stall, hazard-unit stall
//   pred_pc              - sequential / predicted next PC from fetch
//   ex_redirect(_pc)     - EX mispredict correction and its target
//   excp                 - exception taken (target TRAP_VEC)
//   sret, sepc           - supervisor return and its address
//   pc_out, pc_valid     - fetch PC and its validity
//   flush                - kill IF/ID and ID/EX (any redirect event this cycle)
//   redirect_pending     - pending slot occupied
//   misalign             - 1-cycle pulse after taking a target with bits[1:0]!=0
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] TRAP_VEC = DEFAULT_TRAP_VEC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        istall,
  input  logic        hazard_stall,
  input  logic [31:0] pred_pc,
  input  logic        ex_redirect,
  input  logic [31:0] ex_redirect_pc,
  input  logic        excp,
  input  logic        sret,
  input  logic [31:0] sepc,
  output logic [31:0] pc_out,
  output logic        pc_valid,
  output logic        flush,
  output logic        redirect_pending,
  output logic        misalign
);

  state_e      state, state_next;
  cause_e      event_cause;
  logic [31:0] event_target;
  logic [31:0] pc_next;
  logic        misalign_next;
  logic        slot_write, slot_clear, slot_accept;
  cause_e      slot_cause;
  logic [31:0] slot_target;

  // Fixed-priority pick of this cycle's redirect event (raw, unaligned target).
  always_comb begin
    event_cause  = CAUSE_NONE;
    event_target = '0;
    if (excp) begin
      event_cause  = CAUSE_EXCP;
      event_target = TRAP_VEC;
    end else if (sret) begin
      event_cause  = CAUSE_SRET;
      event_target = sepc;
    end else if (ex_redirect) begin
      event_cause  = CAUSE_EXREDIR;
      event_target = ex_redirect_pc;
    end
  end

  assign flush            = (event_cause != CAUSE_NONE);
  assign redirect_pending = (state == PCG_PEND);

  redirect_slot u_slot (
    .clk           (clk),
    .rst           (rst),
    .write         (slot_write),
    .clear         (slot_clear),
    .new_cause     (event_cause),
    .new_target    (align_pc(event_target)),
    .accept        (slot_accept),
    .stored_cause  (slot_cause),
    .stored_target (slot_target)
  );

  // Next-state / next-PC. A redirect overrides hazard_stall; only istall
  // defers it into the slot. The sequential path waits for pc_valid so the
  // reset PC itself gets one valid fetch cycle before advancing.
  always_comb begin
    state_next    = state;
    pc_next       = pc_out;
    slot_write    = 1'b0;
    slot_clear    = 1'b0;
    misalign_next = 1'b0;
    case (state)
      PCG_RUN: begin
        if (flush) begin
          misalign_next = |event_target[1:0];
          if (istall) begin
            slot_write = 1'b1;
            state_next = PCG_PEND;
          end else begin
            pc_next = align_pc(event_target);
          end
        end else if (pc_valid && !istall && !hazard_stall) begin
          pc_next = align_pc(pred_pc);
        end
      end
      PCG_PEND: begin
        if (slot_accept) begin
          misalign_next = |event_target[1:0];
        end
        if (istall) begin
          slot_write = slot_accept;
        end else begin
          pc_next    = slot_accept ? align_pc(event_target) : slot_target;
          slot_clear = 1'b1;
          state_next = PCG_RUN;
        end
      end
      default: state_next = PCG_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= PCG_RUN;
      pc_out   <= RESET_PC;
      pc_valid <= 1'b0;
      misalign <= 1'b0;
    end else begin
      state    <= state_next;
      pc_out   <= pc_next;
      pc_valid <= 1'b1;
      misalign <= misalign_next;
    end
  end

  // slot_cause is consumed inside redirect_slot; kept visible here for debug.
  logic unused_ok;
  assign unused_ok = ^slot_cause;

endmodule
